multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Main control unit of the multicycle RV32I-subset core. Moore FSM that sequences
//  fetch/decode/execute and drives the 2-bit select lines of the datapath mux_4_1
//  instances (alu_src_a, alu_src_b, result_src), plus the write strobes. Selects are
//  consumed directly as mux `sel`. Encoding 2'b11 is never driven.
// PARAMETERS
//  SEL_W      2  width of every datapath mux select (must match mux_4_1 sel)
//  ALUCTRL_W  3  width of alu_control
// PORTS
//  clk          in   1      single core clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  op           in   7      instr[6:0] from instruction register
//  funct3       in   3      instr[14:12]
//  funct7b5     in   1      instr[30]
//  zero         in   1      ALU zero flag (same cycle as BEQ state)
//  pc_write     out  1      PC register enable
//  adr_src      out  1      memory address mux: 0 PC, 1 ALUOut
//  mem_write    out  1      data memory write strobe
//  ir_write     out  1      IR/OldPC enable
//  reg_write    out  1      register file write strobe
//  result_src   out  SEL_W  00 ALUOut, 01 Data, 10 ALUResult
//  alu_src_a    out  SEL_W  00 PC, 01 OldPC, 10 A(RD1)
//  alu_src_b    out  SEL_W  00 WriteData(RD2), 01 ImmExt, 10 const 4
//  alu_control  out  ALUCTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt
//  imm_src      out  2      00 I, 01 S, 10 B, 11 J (combinational from op)
//  illegal_op   out  1      1-cycle pulse in DECODE on unsupported opcode
// BEHAVIOUR
//  - rst_n low: state <= FETCH asynchronously; all strobes/pulses forced 0, all selects
//    00, alu_control 000. First fetch strobes on first rising edge after rst_n rises.
//  - Reset mid-instruction: abandon instruction, no partial strobe after rst_n falls.
//  - Outputs are pure decode of registered state (Moore); only pc_write uses zero:
//    pc_write = pc_update | (branch & zero).
//  - States / outputs (unlisted = 0/00) / next:
//    FETCH   : ir_write=1, a=00, b=10, aluop=00, result=10, pc_update=1 -> DECODE
//    DECODE  : a=01, b=01, aluop=00 -> lw/sw(0000011/0100011) MEMADR, R(0110011)
//              EXEC_R, I-ALU(0010011) EXEC_I, jal(1101111) JAL, beq(1100011) BEQ,
//              other: illegal_op=1 -> FETCH
//    MEMADR  : a=10, b=01, aluop=00 -> op[5]=0 MEMREAD, op[5]=1 MEMWRITE
//    MEMREAD : result=00, adr_src=1 -> MEMWB
//    MEMWB   : result=01, reg_write=1 -> FETCH
//    MEMWRITE: result=00, adr_src=1, mem_write=1 -> FETCH
//    EXEC_R  : a=10, b=00, aluop=10 -> ALUWB
//    EXEC_I  : a=10, b=01, aluop=10 -> ALUWB
//    ALUWB   : result=00, reg_write=1 -> FETCH
//    JAL     : a=01, b=10, aluop=00, result=00, pc_update=1 -> ALUWB
//    BEQ     : a=10, b=00, aluop=01, result=00, branch=1 -> FETCH
//  - Latency (cycles incl. FETCH): lw 5, sw 4, R 4, I 4, jal 4, beq 3.
//  - ALU decode: aluop 00 add; 01 sub; 10 by funct3: 000 -> sub iff op[5]&funct7b5
//    else add; 010 slt; 110 or; 111 and; other funct3 -> add.
//  - Unreachable state encodings -> FETCH next cycle, outputs as reset values.
// STRUCTURE
//  - ctrl_pkg: state_t enum, opcode localparams, SRCA_/SRCB_/RES_ select codes,
//    ALU_* codes, aluop_t.
//  - Sub-module alu_decoder (aluop, funct3, op5, funct7b5 -> alu_control), comb.
//  - imm_src decode inline (comb on op).
// TESTING
//  1 lw (op=0000011): states F,D,MA,MR,WB; MEMREAD adr_src=1; MEMWB result=01,reg_write=1.
//  2 sw (op=0100011): MEMWRITE mem_write=1 one cycle only; imm_src=01; back to FETCH at 4.
//  3 R sub (funct3=000,funct7b5=1): EXEC_R alu_control=001; add (funct7b5=0) -> 000; I
//    addi with funct7b5=1 -> 000 (op[5]=0).
//  4 beq: zero=1 -> pc_write=1 in BEQ, alu_control=001; zero=0 -> pc_write=0; 3 cycles.
//  5 jal: JAL a=01,b=10,pc_write=1, then ALUWB reg_write=1; op=1111111 -> illegal_op
//    pulse, next FETCH.
//  6 rst_n low in MEMADR of sw: mem_write never asserts; all outputs 0 during reset;
//    FETCH strobes on first edge after release.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle core control unit:
// FSM states, opcodes, datapath mux select codes and ALU operation codes.
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } aluop_t;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRtype = 7'b0110011;
  localparam logic [6:0] OpItype = 7'b0010011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpBeq   = 7'b1100011;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcAReg   = 2'b10;

  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the multicycle control FSM (master) and the datapath (slave):
// instruction fields and ALU flag in, strobes and mux selects out.
interface multicycle_ctrl_fsm_if #(
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned ALUCTRL_W = 3
);

  logic [6:0]           op;
  logic [2:0]           funct3;
  logic                 funct7b5;
  logic                 zero;
  logic                 pc_write;
  logic                 adr_src;
  logic                 mem_write;
  logic                 ir_write;
  logic                 reg_write;
  logic [SEL_W-1:0]     result_src;
  logic [SEL_W-1:0]     alu_src_a;
  logic [SEL_W-1:0]     alu_src_b;
  logic [ALUCTRL_W-1:0] alu_control;
  logic [1:0]           imm_src;
  logic                 illegal_op;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal_op
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal_op
  );

endinterface

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's coarse aluop plus instruction
// function fields onto the ALU operation code.
module multicycle_ctrl_fsm_alu_decoder
  import multicycle_ctrl_fsm_pkg::*;
(
  input  aluop_t     aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = AluAdd;
    case (aluop_i)
      AluOpAdd: alu_control_o = AluAdd;
      AluOpSub: alu_control_o = AluSub;
      AluOpFunct: begin
        case (funct3_i)
          // Only R-type sub has op[5] set; addi with imm[10]=1 must stay an add.
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? AluSub : AluAdd;
          3'b010:  alu_control_o = AluSlt;
          3'b110:  alu_control_o = AluOr;
          3'b111:  alu_control_o = AluAnd;
          default: alu_control_o = AluAdd;
        endcase
      end
      default: alu_control_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM of the multicycle RV32I-subset core: sequences
// fetch/decode/execute and drives datapath strobes and mux selects.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned ALUCTRL_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_ctrl_fsm_if.master  ctrl_io
);

  state_t               state_q, state_d;
  aluop_t               aluop;
  logic                 pc_update, branch;
  logic                 ir_write, adr_src, mem_write, reg_write, illegal_op;
  logic [SEL_W-1:0]     result_src, alu_src_a, alu_src_b;
  logic [ALUCTRL_W-1:0] alu_ctl;
  logic [1:0]           imm_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = StFetch;
    aluop      = AluOpAdd;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    result_src = ResAluOut;
    alu_src_a  = SrcAPc;
    alu_src_b  = SrcBReg;
    unique case (state_q)
      StFetch: begin
        ir_write   = 1'b1;
        pc_update  = 1'b1;
        alu_src_b  = SrcBFour;
        result_src = ResAluResult;
        state_d    = StDecode;
      end
      StDecode: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
        case (ctrl_io.op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecR;
          OpItype:         state_d = StExecI;
          OpJal:           state_d = StJal;
          OpBeq:           state_d = StBeq;
          default: begin
            illegal_op = 1'b1;
            state_d    = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = SrcAReg;
        alu_src_b = SrcBImm;
        state_d   = ctrl_io.op[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_src = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        result_src = ResData;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = StFetch;
      end
      StExecR: begin
        alu_src_a = SrcAReg;
        alu_src_b = SrcBReg;
        aluop     = AluOpFunct;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = SrcAReg;
        alu_src_b = SrcBImm;
        aluop     = AluOpFunct;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StJal: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBFour;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      StBeq: begin
        alu_src_a = SrcAReg;
        alu_src_b = SrcBReg;
        aluop     = AluOpSub;
        branch    = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    case (ctrl_io.op)
      OpStore: imm_src = ImmS;
      OpBeq:   imm_src = ImmB;
      OpJal:   imm_src = ImmJ;
      default: imm_src = ImmI;
    endcase
  end

  multicycle_ctrl_fsm_alu_decoder u_alu_decoder (
    .aluop_i       (aluop),
    .funct3_i      (ctrl_io.funct3),
    .op5_i         (ctrl_io.op[5]),
    .funct7b5_i    (ctrl_io.funct7b5),
    .alu_control_o (alu_ctl)
  );

  // State is forced to FETCH during reset, but FETCH strobes must not fire until release.
  assign ctrl_io.pc_write    = rst_n & (pc_update | (branch & ctrl_io.zero));
  assign ctrl_io.ir_write    = rst_n & ir_write;
  assign ctrl_io.adr_src     = rst_n & adr_src;
  assign ctrl_io.mem_write   = rst_n & mem_write;
  assign ctrl_io.reg_write   = rst_n & reg_write;
  assign ctrl_io.illegal_op  = rst_n & illegal_op;
  assign ctrl_io.result_src  = rst_n ? result_src : '0;
  assign ctrl_io.alu_src_a   = rst_n ? alu_src_a : '0;
  assign ctrl_io.alu_src_b   = rst_n ? alu_src_b : '0;
  assign ctrl_io.alu_control = rst_n ? alu_ctl : '0;
  assign ctrl_io.imm_src     = rst_n ? imm_src : 2'b00;

endmodule
